// File: rtl/axi4_lite_uart_tx.sv
// AXI4-Lite UART transmitter: 8N1, LSB first, fed from a small TX FIFO with a
// run-time programmable bit period (DIV, clock cycles per bit).
`timescale 1ns/1ps
module axi4_lite_uart_tx #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int CLK_DIV    = 868,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] s_awaddr,
  input  logic                  s_awvalid,
  output logic                  s_awready,
  input  logic [DATA_WIDTH-1:0] s_wdata,
  input  logic [3:0]            s_wstrb,
  input  logic                  s_wvalid,
  output logic                  s_wready,
  output logic [1:0]            s_bresp,
  output logic                  s_bvalid,
  input  logic                  s_bready,
  input  logic [ADDR_WIDTH-1:0] s_araddr,
  input  logic                  s_arvalid,
  output logic                  s_arready,
  output logic [DATA_WIDTH-1:0] s_rdata,
  output logic [1:0]            s_rresp,
  output logic                  s_rvalid,
  input  logic                  s_rready,
  output logic                  uart_tx,
  output logic                  tx_busy
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] CNT_ONE   = (PW+1)'(1);
  localparam logic [PW:0] CNT_FULL  = (PW+1)'(FIFO_DEPTH);
  localparam logic [PW:0] CNT_ZERO  = (PW+1)'(0);
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_START   = 2'd1;
  localparam logic [1:0] ST_DATA    = 2'd2;
  localparam logic [1:0] ST_STOP    = 2'd3;
  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic                  aw_rdy_r, bvalid_r, ar_rdy_r, rvalid_r;
  logic [1:0]            bresp_r, rresp_r;
  logic [DATA_WIDTH-1:0] rdata_r;
  logic [15:0]           div_r, div_lat_r, cnt_r;
  logic [7:0]            fifo_mem_r [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_r, rd_ptr_r;
  logic [PW:0]           count_r;
  logic [1:0]            state_r;
  logic [7:0]            shift_r;
  logic [2:0]            bit_idx_r;
  logic                  uart_tx_r, tx_busy_r;

  logic                  wr_hs_s, rd_hs_s, full_s, empty_s, push_s, pop_s;
  logic [1:0]            wsel_s, wr_resp_s, rd_resp_s;
  logic [15:0]           div_new_s, div_clamp_s;
  logic [31:0]           status_s;
  logic [DATA_WIDTH-1:0] rd_data_s;
  logic                  unused_s;

  assign wr_hs_s = aw_rdy_r & s_awvalid & s_wvalid;
  assign rd_hs_s = ar_rdy_r & s_arvalid;
  assign wsel_s  = s_awaddr[3:2];
  assign full_s  = (count_r == CNT_FULL);
  assign empty_s = (count_r == CNT_ZERO);
  // Fullness is taken from the pre-pop count, so a push to a full FIFO loses even if a pop lands this edge.
  assign push_s  = wr_hs_s & (wsel_s == 2'd0) & s_wstrb[0] & ~full_s;
  assign pop_s   = ~empty_s & ((state_r == ST_IDLE) | ((state_r == ST_STOP) & (cnt_r == 16'd0)));
  assign unused_s = ^{s_awaddr[ADDR_WIDTH-1:4], s_awaddr[1:0], s_araddr[ADDR_WIDTH-1:4],
                      s_araddr[1:0], s_wdata[DATA_WIDTH-1:16], s_wstrb[3:2]};

  // Write response code and byte-merged, clamped DIV value
  always_comb begin
    wr_resp_s = RESP_OKAY;
    case (wsel_s)
      2'd0:    wr_resp_s = (s_wstrb[0] & full_s) ? RESP_SLVERR : RESP_OKAY;
      2'd1:    wr_resp_s = RESP_OKAY;
      2'd2:    wr_resp_s = RESP_OKAY;
      default: wr_resp_s = RESP_SLVERR;
    endcase
    div_new_s[7:0]  = s_wstrb[0] ? s_wdata[7:0]  : div_r[7:0];
    div_new_s[15:8] = s_wstrb[1] ? s_wdata[15:8] : div_r[15:8];
    if (div_new_s < 16'd2) begin
      div_clamp_s = 16'd2;
    end else begin
      div_clamp_s = div_new_s;
    end
  end

  // Read data mux including STATUS assembly
  always_comb begin
    status_s           = 32'd0;
    status_s[0]        = full_s;
    status_s[1]        = empty_s;
    status_s[2]        = (state_r != ST_IDLE);
    status_s[4 +: PW+1] = count_r;
    rd_data_s = {DATA_WIDTH{1'b0}};
    rd_resp_s = RESP_OKAY;
    case (s_araddr[3:2])
      2'd0:    rd_data_s = {DATA_WIDTH{1'b0}};
      2'd1:    rd_data_s = DATA_WIDTH'(status_s);
      2'd2:    rd_data_s = DATA_WIDTH'(div_r);
      default: rd_resp_s = RESP_SLVERR;
    endcase
  end

  // AXI write address/data/response channel
  always_ff @(posedge clk) begin
    if (rst) begin
      aw_rdy_r <= 1'b0;
      bvalid_r <= 1'b0;
      bresp_r  <= RESP_OKAY;
    end else begin
      aw_rdy_r <= s_awvalid & s_wvalid & ~bvalid_r & ~aw_rdy_r;
      if (wr_hs_s) begin
        bvalid_r <= 1'b1;
        bresp_r  <= wr_resp_s;
      end else if (bvalid_r & s_bready) begin
        bvalid_r <= 1'b0;
      end
    end
  end

  // AXI read address/data channel
  always_ff @(posedge clk) begin
    if (rst) begin
      ar_rdy_r <= 1'b0;
      rvalid_r <= 1'b0;
      rresp_r  <= RESP_OKAY;
      rdata_r  <= {DATA_WIDTH{1'b0}};
    end else begin
      ar_rdy_r <= s_arvalid & ~rvalid_r & ~ar_rdy_r;
      if (rd_hs_s) begin
        rvalid_r <= 1'b1;
        rdata_r  <= rd_data_s;
        rresp_r  <= rd_resp_s;
      end else if (rvalid_r & s_rready) begin
        rvalid_r <= 1'b0;
      end
    end
  end

  // DIV register
  always_ff @(posedge clk) begin
    if (rst) begin
      div_r <= 16'(CLK_DIV);
    end else if (wr_hs_s && (wsel_s == 2'd2)) begin
      div_r <= div_clamp_s;
    end
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_mem_r[wr_ptr_r] <= s_wdata[7:0];
    end
  end

  // FIFO pointers and level
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= CNT_ZERO;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PW'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PW'(1);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Transmit FSM; every state/bit lasts div_lat_r cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      cnt_r     <= 16'd0;
      div_lat_r <= 16'd2;
      shift_r   <= 8'd0;
      bit_idx_r <= 3'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (pop_s) begin
            shift_r   <= fifo_mem_r[rd_ptr_r];
            div_lat_r <= div_r;
            cnt_r     <= div_r - 16'd1;
            state_r   <= ST_START;
          end
        end
        ST_START: begin
          if (cnt_r == 16'd0) begin
            cnt_r     <= div_lat_r - 16'd1;
            bit_idx_r <= 3'd0;
            state_r   <= ST_DATA;
          end else begin
            cnt_r <= cnt_r - 16'd1;
          end
        end
        ST_DATA: begin
          if (cnt_r == 16'd0) begin
            cnt_r   <= div_lat_r - 16'd1;
            shift_r <= {1'b0, shift_r[7:1]};
            if (bit_idx_r == 3'd7) begin
              state_r <= ST_STOP;
            end else begin
              bit_idx_r <= bit_idx_r + 3'd1;
            end
          end else begin
            cnt_r <= cnt_r - 16'd1;
          end
        end
        ST_STOP: begin
          if (cnt_r == 16'd0) begin
            if (pop_s) begin
              shift_r   <= fifo_mem_r[rd_ptr_r];
              div_lat_r <= div_r;
              cnt_r     <= div_r - 16'd1;
              state_r   <= ST_START;
            end else begin
              state_r <= ST_IDLE;
            end
          end else begin
            cnt_r <= cnt_r - 16'd1;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  // Registered line driver and busy flag
  always_ff @(posedge clk) begin
    if (rst) begin
      uart_tx_r <= 1'b1;
      tx_busy_r <= 1'b0;
    end else begin
      case (state_r)
        ST_START: uart_tx_r <= 1'b0;
        ST_DATA:  uart_tx_r <= shift_r[0];
        default:  uart_tx_r <= 1'b1;
      endcase
      if (push_s) begin
        tx_busy_r <= 1'b1;
      end else if ((state_r == ST_STOP) && (cnt_r == 16'd0) && empty_s) begin
        tx_busy_r <= 1'b0;
      end
    end
  end

  assign s_awready = aw_rdy_r;
  assign s_wready  = aw_rdy_r;
  assign s_bvalid  = bvalid_r;
  assign s_bresp   = bresp_r;
  assign s_arready = ar_rdy_r;
  assign s_rvalid  = rvalid_r;
  assign s_rdata   = rdata_r;
  assign s_rresp   = rresp_r;
  assign uart_tx   = uart_tx_r;
  assign tx_busy   = tx_busy_r;
endmodule

// File: tb/tb_axi4_lite_uart_tx.sv
// Self-checking bench for axi4_lite_uart_tx: register table, frame timing,
// FIFO overflow, handshake stalls, mid-frame reset and randomized traffic.
`timescale 1ns/1ps
module tb_axi4_lite_uart_tx;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] s_awaddr, s_wdata, s_araddr, s_rdata;
  logic [3:0]  s_wstrb;
  logic        s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic        s_arvalid, s_arready, s_rvalid, s_rready, uart_tx, tx_busy;
  logic [1:0]  s_bresp, s_rresp;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  axi4_lite_uart_tx #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .CLK_DIV(868), .FIFO_DEPTH(8)) dut (
    .clk(clk), .rst(rst),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .uart_tx(uart_tx), .tx_busy(tx_busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Line receiver: decodes each frame with the current expected bit period.
  bit         rx_en = 1'b0;
  int         rx_div = 4;
  logic [7:0] rx_q[$];
  int         rx_st_q[$];
  logic       rx_samp [0:127];

  initial begin : rx_proc
    int d, st;
    logic [9:0] bits;
    bit abort, stable;
    forever begin
      @(negedge clk);
      if (rx_en && !rst && uart_tx === 1'b0) begin
        d = rx_div; st = cyc; abort = 1'b0; bits = 10'd0;
        for (int k = 0; k < 10*d; k++) begin
          if (k > 0) @(negedge clk);
          if (rst) begin abort = 1'b1; break; end
          rx_samp[k] = uart_tx;
          if (k % d == d/2) bits[k/d] = uart_tx;
        end
        if (!abort) begin
          stable = 1'b1;
          for (int j = 0; j < 10*d; j++) if (rx_samp[j] !== bits[j/d]) stable = 1'b0;
          chk("rx_frame_shape", {29'd0, stable, bits[9], bits[0]}, 32'h6);
          rx_q.push_back(bits[8:1]);
          rx_st_q.push_back(st);
        end
      end
    end
  end

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] st,
                           output logic [1:0] resp, output int hs);
    int t;
    s_awaddr = a; s_wdata = d; s_wstrb = st; s_awvalid = 1'b1; s_wvalid = 1'b1;
    t = 0;
    while (!s_awready && t < 20) begin @(posedge clk); #1; t++; end
    chk("aw_ready_seen", 32'(s_awready), 32'd1);
    @(posedge clk); #1;
    hs = cyc;
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    t = 0;
    while (!s_bvalid && t < 20) begin @(posedge clk); #1; t++; end
    chk("bvalid_seen", 32'(s_bvalid), 32'd1);
    resp = s_bresp;
    s_bready = 1'b1;
    @(posedge clk); #1;
    s_bready = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
    int t;
    s_araddr = a; s_arvalid = 1'b1;
    t = 0;
    while (!s_arready && t < 20) begin @(posedge clk); #1; t++; end
    chk("ar_ready_seen", 32'(s_arready), 32'd1);
    @(posedge clk); #1;
    s_arvalid = 1'b0;
    t = 0;
    while (!s_rvalid && t < 20) begin @(posedge clk); #1; t++; end
    chk("rvalid_seen", 32'(s_rvalid), 32'd1);
    d = s_rdata; resp = s_rresp;
    s_rready = 1'b1;
    @(posedge clk); #1;
    s_rready = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int t;
    t = 0;
    while (tx_busy && t < limit) begin @(posedge clk); #1; t++; end
    chk("idle_reached", 32'(tx_busy), 32'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  // One byte from idle: exact start latency, frame length and busy fall.
  task automatic send_one(input logic [31:0] div_wr, input int div_eff, input logic [7:0] b);
    logic [1:0] resp; int h;
    axi_write(32'h8, div_wr, 4'hF, resp, h);
    rx_div = div_eff; rx_q.delete(); rx_st_q.delete();
    axi_write(32'h0, {24'd0, b}, 4'h1, resp, h);
    chk("one_resp", 32'(resp), 32'd0);
    chk("one_busy_rise", 32'(tx_busy), 32'd1);
    while (cyc < h + 10*div_eff) begin @(posedge clk); #1; end
    chk("one_busy_last", 32'(tx_busy), 32'd1);
    @(posedge clk); #1;
    chk("one_busy_fall", 32'(tx_busy), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("one_frames", 32'(rx_q.size()), 32'd1);
    if (rx_q.size() == 1) begin
      chk("one_byte", 32'(rx_q[0]), 32'(b));
      chk("one_start_lat", 32'(rx_st_q[0] - h), 32'd2);
    end
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  eresp;
    logic [31:0] edata;
  } vec_t;

  vec_t tbl[17];
  logic [1:0]  resp;
  logic [31:0] rd;
  int          h, h1;
  logic [7:0]  exp_q[$];

  initial begin
    rst = 1'b1; s_awaddr = 32'd0; s_wdata = 32'd0; s_wstrb = 4'h0; s_awvalid = 1'b0;
    s_wvalid = 1'b0; s_bready = 1'b0; s_araddr = 32'd0; s_arvalid = 1'b0; s_rready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_uart_tx", 32'(uart_tx), 32'd1);
    chk("rst_tx_busy", 32'(tx_busy), 32'd0);
    chk("rst_valids", {28'd0, s_awready, s_bvalid, s_arready, s_rvalid}, 32'd0);
    chk("rst_resps", {28'd0, s_bresp, s_rresp}, 32'd0);
    chk("rst_rdata", s_rdata, 32'd0);
    rx_en = 1'b1;

    tbl[0]  = '{1'b0, 32'h4,        32'h0,        4'hF, 2'b00, 32'h2};
    tbl[1]  = '{1'b0, 32'h8,        32'h0,        4'hF, 2'b00, 32'd868};
    tbl[2]  = '{1'b0, 32'h0,        32'h0,        4'hF, 2'b00, 32'h0};
    tbl[3]  = '{1'b0, 32'hC,        32'h0,        4'hF, 2'b10, 32'h0};
    tbl[4]  = '{1'b1, 32'hC,        32'hFF,       4'hF, 2'b10, 32'h0};
    tbl[5]  = '{1'b0, 32'h8,        32'h0,        4'hF, 2'b00, 32'd868};
    tbl[6]  = '{1'b1, 32'h8,        32'h1,        4'hF, 2'b00, 32'h0};
    tbl[7]  = '{1'b0, 32'h8,        32'h0,        4'hF, 2'b00, 32'h2};
    tbl[8]  = '{1'b1, 32'h8,        32'h0,        4'hF, 2'b00, 32'h0};
    tbl[9]  = '{1'b0, 32'h8,        32'h0,        4'hF, 2'b00, 32'h2};
    tbl[10] = '{1'b1, 32'h8,        32'hABC12345, 4'hF, 2'b00, 32'h0};
    tbl[11] = '{1'b0, 32'h8,        32'h0,        4'hF, 2'b00, 32'h2345};
    tbl[12] = '{1'b1, 32'h0,        32'h55,       4'h0, 2'b00, 32'h0};
    tbl[13] = '{1'b0, 32'h4,        32'h0,        4'hF, 2'b00, 32'h2};
    tbl[14] = '{1'b1, 32'h8,        32'h4,        4'hF, 2'b00, 32'h0};
    tbl[15] = '{1'b0, 32'h8,        32'h0,        4'hF, 2'b00, 32'h4};
    tbl[16] = '{1'b0, 32'h10000008, 32'h0,        4'hF, 2'b00, 32'h4};
    foreach (tbl[i]) begin
      if (tbl[i].wr) begin
        axi_write(tbl[i].addr, tbl[i].data, tbl[i].strb, resp, h);
        chk($sformatf("tbl%0d_bresp", i), 32'(resp), 32'(tbl[i].eresp));
      end else begin
        axi_read(tbl[i].addr, rd, resp);
        chk($sformatf("tbl%0d_rresp", i), 32'(resp), 32'(tbl[i].eresp));
        chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].edata);
      end
    end

    send_one(32'd4, 4, 8'hA5);
    send_one(32'd1, 2, 8'h00);

    // Ten back-to-back pushes into an 8-deep FIFO with one byte already on the line
    axi_write(32'h8, 32'd4, 4'hF, resp, h);
    rx_div = 4; rx_q.delete(); rx_st_q.delete(); exp_q.delete();
    for (int i = 0; i < 10; i++) begin
      axi_write(32'h0, 32'(8'h3C + 8'(i*29)), 4'h1, resp, h);
      if (i == 0) h1 = h;
      if (i < 9) exp_q.push_back(8'h3C + 8'(i*29));
      chk($sformatf("burst%0d_resp", i), 32'(resp), (i < 9) ? 32'd0 : 32'd2);
    end
    axi_read(32'h4, rd, resp);
    chk("burst_status_full", rd, 32'h85);
    wait_idle(2000);
    chk("burst_frames", 32'(rx_q.size()), 32'd9);
    if (rx_q.size() == 9) begin
      chk("burst_first_lat", 32'(rx_st_q[0] - h1), 32'd2);
      for (int i = 0; i < 9; i++) begin
        chk($sformatf("burst_byte%0d", i), 32'(rx_q[i]), 32'(exp_q[i]));
        if (i > 0) chk($sformatf("burst_gap%0d", i), 32'(rx_st_q[i] - rx_st_q[i-1]), 32'd40);
      end
    end
    axi_read(32'h4, rd, resp);
    chk("burst_status_empty", rd, 32'h2);

    // Write response held by s_bready=0 while a second write waits
    s_awaddr = 32'h8; s_wdata = 32'd7; s_wstrb = 4'hF; s_awvalid = 1'b1; s_wvalid = 1'b1;
    for (int t = 0; t < 20 && !s_bvalid; t++) begin @(posedge clk); #1; end
    s_wdata = 32'd9;
    for (int t = 0; t < 5; t++) begin
      @(posedge clk); #1;
      chk("bstall_hold", {30'd0, s_bvalid, s_awready}, 32'h2);
    end
    s_bready = 1'b1; @(posedge clk); #1; s_bready = 1'b0;
    chk("bstall_release", 32'(s_bvalid), 32'd0);
    for (int t = 0; t < 20 && !s_awready; t++) begin @(posedge clk); #1; end
    @(posedge clk); #1;
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    for (int t = 0; t < 20 && !s_bvalid; t++) begin @(posedge clk); #1; end
    chk("bstall_second", {29'd0, s_bvalid, s_bresp}, 32'h4);
    s_bready = 1'b1; @(posedge clk); #1; s_bready = 1'b0;

    // Read data held by s_rready=0, write channel keeps working meanwhile
    s_araddr = 32'h8; s_arvalid = 1'b1;
    for (int t = 0; t < 20 && !s_rvalid; t++) begin @(posedge clk); #1; end
    s_arvalid = 1'b0;
    for (int t = 0; t < 5; t++) begin
      @(posedge clk); #1;
      chk("rstall_hold", s_rdata, 32'd9);
      chk("rstall_valid", 32'(s_rvalid), 32'd1);
    end
    axi_write(32'h8, 32'd5, 4'hF, resp, h);
    chk("rstall_after_wr", s_rdata, 32'd9);
    s_rready = 1'b1; @(posedge clk); #1; s_rready = 1'b0;
    chk("rstall_release", 32'(s_rvalid), 32'd0);
    axi_read(32'h8, rd, resp);
    chk("rstall_div", rd, 32'd5);

    // Reset mid-DATA with three bytes queued and a response pending
    axi_write(32'h8, 32'd4, 4'hF, resp, h);
    rx_div = 4; rx_q.delete(); rx_st_q.delete();
    for (int i = 0; i < 4; i++) begin
      axi_write(32'h0, 32'(8'h31 + 8'(i)), 4'h1, resp, h);
      if (i == 0) h1 = h;
    end
    s_awaddr = 32'hC; s_awvalid = 1'b1; s_wvalid = 1'b1;
    for (int t = 0; t < 20 && !s_bvalid; t++) begin @(posedge clk); #1; end
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    chk("rstmid_pending", 32'(s_bvalid), 32'd1);
    while (cyc < h1 + 14) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rstmid_line", {30'd0, uart_tx, tx_busy}, 32'h2);
    chk("rstmid_bvalid", 32'(s_bvalid), 32'd0);
    rst = 1'b0;
    axi_read(32'h4, rd, resp);
    chk("rstmid_status", rd, 32'h2);
    axi_read(32'h8, rd, resp);
    chk("rstmid_div", rd, 32'd868);
    begin
      bit quiet;
      quiet = 1'b1;
      repeat (20) begin @(posedge clk); #1; if (uart_tx !== 1'b1 || tx_busy !== 1'b0) quiet = 1'b0; end
      chk("rstmid_quiet", 32'(quiet), 32'd1);
    end
    chk("rstmid_no_frame", 32'(rx_q.size()), 32'd0);

    // Randomized bursts against a byte-queue / frame-period model
    for (int it = 0; it < 12; it++) begin
      int d, n;
      logic [7:0] b;
      d = $urandom_range(2, 6);
      n = $urandom_range(1, 9);
      axi_write(32'h8, 32'(d), 4'hF, resp, h);
      rx_div = d; rx_q.delete(); rx_st_q.delete(); exp_q.delete();
      for (int i = 0; i < n; i++) begin
        b = 8'($urandom);
        axi_write(32'h0, {24'd0, b}, 4'h1, resp, h);
        chk("rand_resp", 32'(resp), 32'd0);
        exp_q.push_back(b);
      end
      wait_idle(10*d*(n+2) + 100);
      chk($sformatf("rand%0d_frames", it), 32'(rx_q.size()), 32'(n));
      if (rx_q.size() == n) begin
        for (int i = 0; i < n; i++) begin
          chk($sformatf("rand%0d_byte%0d", it, i), 32'(rx_q[i]), 32'(exp_q[i]));
          if (i > 0) chk($sformatf("rand%0d_gap%0d", it, i), 32'(rx_st_q[i] - rx_st_q[i-1]), 32'(10*d));
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
